// File: rtl/ring_osc_pkg.sv
// Shared constants and elaboration helpers for the flop-based ring oscillator model.
package ring_osc_pkg;

    localparam logic MODE_DC = 1'b0;
    localparam logic MODE_AC = 1'b1;

    // Ring length must be odd so the ring can never settle while enabled.
    function automatic bit stages_ok(input int n);
        return (n >= 3) && ((n % 2) == 1);
    endfunction

    // Reset pattern: odd stages high, even stages low (N=5 gives 0,1,0,1,0).
    function automatic logic reset_value(input int idx);
        return logic'(idx % 2);
    endfunction

endpackage

// File: rtl/ring_stage.sv
// One registered ring stage: an inverter, or a NAND with enable for stage 0.
module ring_stage #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   IS_NAND = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = IS_NAND ? ~(en_i & d_i) : ~d_i;
    end

    // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ring_oscillator.sv
// Cycle-accurate odd-length ring oscillator with measurement, DC-stress and
// AC-stress operation; one edge advances one stage per clock.
module ring_oscillator
    import ring_osc_pkg::*;
#(
    parameter int N_STAGES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic Mode,
    input  logic Stress,
    output logic OUT
);

    localparam bit N_OK = stages_ok(N_STAGES);

    if (!N_OK) begin : g_bad_n
        $error("ring_oscillator: N_STAGES must be odd and >= 3");
    end

    logic [N_STAGES-1:0] stage_q;
    logic                ring_en;
    logic                out_d;
    logic                out_q;

    // Only DC stress breaks the loop; AC stress keeps the ring toggling.
    always_comb begin
        ring_en = ~(Stress & (Mode == MODE_DC));
    end

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        if (i == 0) begin : g_nand
            ring_stage #(
                .RST_VAL (reset_value(0)),
                .IS_NAND (1'b1)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en_i (ring_en),
                .d_i  (stage_q[N_STAGES-1]),
                .q_o  (stage_q[0])
            );
        end else begin : g_inv
            ring_stage #(
                .RST_VAL (reset_value(i)),
                .IS_NAND (1'b0)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en_i (1'b1),
                .d_i  (stage_q[i-1]),
                .q_o  (stage_q[i])
            );
        end
    end

    // AC stress hides the tap from the probe while the ring keeps running.
    always_comb begin
        out_d = (Stress && (Mode == MODE_AC)) ? 1'b0 : stage_q[N_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_ring_oscillator.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares.
module tb_ring_oscillator;

    localparam int N = 5;

    typedef struct packed {
        logic [N-1:0] stages;
        logic         out;
        logic         chk;
    } exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic Mode   = 1'b0;
    logic Stress = 1'b0;
    logic OUT;

    ring_oscillator #(.N_STAGES(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .Mode   (Mode),
        .Stress (Stress),
        .OUT    (OUT)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit   m_s[N];
    bit   m_out;
    bit   chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: apply the ring rules to an array of stage values.
    function automatic void model_step(input bit r, input bit m, input bit s);
        bit   nxt[N];
        bit   en;
        exp_t e;
        en = !(s && !m);
        if (r) begin
            for (int i = 0; i < N; i++) m_s[i] = (i % 2) == 1;
            m_out = 1'b0;
        end else begin
            nxt[0] = !(en && m_s[N-1]);
            for (int i = 1; i < N; i++) nxt[i] = !m_s[i-1];
            m_out = (s && m) ? 1'b0 : m_s[N-1];
            m_s   = nxt;
        end
        for (int i = 0; i < N; i++) e.stages[i] = m_s[i];
        e.out = m_out;
        e.chk = chk_en && !r && en && !(s && m);
        exp_q.push_back(e);
    endfunction

    task automatic drive(input bit r, input bit m, input bit s, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst    = r;
            Mode   = m;
            Stress = s;
            model_step(r, m, s);
        end
    endtask

    // Monitor: compares every registered output and, in clean running windows,
    // the spacing between OUT toggles (skipping the first, possibly partial, gap).
    int   mon_cyc  = 0;
    int   mon_last = 0;
    int   mon_nt   = 0;
    logic mon_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stages", 32'(dut.stage_q), 32'(e.stages));
                check("OUT", 32'(OUT), 32'(e.out));
                if (!e.chk) begin
                    mon_nt = 0;
                end else if (OUT !== mon_prev) begin
                    mon_nt++;
                    if (mon_nt >= 3) check("half_period", 32'(mon_cyc - mon_last), 32'(N));
                    mon_last = mon_cyc;
                end
                mon_prev = OUT;
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 2);
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 50);  // measurement
        drive(1'b0, 1'b1, 1'b0, 30);  // measurement, Mode ignored
        drive(1'b0, 1'b0, 1'b1, 45);  // DC stress
        drive(1'b0, 1'b1, 1'b1, 30);  // AC stress
        drive(1'b0, 1'b0, 1'b0, 20);
        drive(1'b0, 1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 1'b1, 20);
        drive(1'b0, 1'b1, 1'b1, 20);
        drive(1'b0, 1'b0, 1'b0, 13);
        drive(1'b1, 1'b0, 1'b0, 1);   // mid-oscillation reset
        drive(1'b0, 1'b0, 1'b0, 40);
        chk_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            drive($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(1, 25)));
        end
        @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
